// File: rtl/board_scan_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | board_scan_controller_pkg                                          |
// | Shared constants and helpers for the 4x4 board scan controller.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package board_scan_controller_pkg;

  localparam int TILE_STATE_W = 4;
  localparam int BOARD_DIM    = 4;
  localparam int BOARD_BITS   = BOARD_DIM * BOARD_DIM * TILE_STATE_W;
  localparam int CNT_W        = 12;

  localparam int TILE       = 106;
  localparam int GAP        = 8;
  localparam int BOARD_X0   = 88;
  localparam int BOARD_Y0   = 8;
  localparam int V_ACTIVE   = 480;
  localparam int RENDER_LAT = 2;
  localparam logic [11:0] BG_COLOR = 12'hBAA;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [TILE_STATE_W-1:0] tile_state_t;

  // Tiles are packed row-major, so the index is simply {row, col}.
  function automatic logic [3:0] tile_index(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_scan_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | board_scan_controller_if                                           |
// | Board-image write handshake between game logic and the controller. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface board_scan_controller_if;
  import board_scan_controller_pkg::*;

  logic                  board_wr_valid;
  logic [BOARD_BITS-1:0] board_wr_data;
  logic                  board_wr_ready;
  logic                  frame_swap;

  modport master (
    output board_wr_valid,
    output board_wr_data,
    input  board_wr_ready,
    input  frame_swap
  );

  modport slave (
    input  board_wr_valid,
    input  board_wr_data,
    output board_wr_ready,
    output frame_swap
  );

endinterface
`default_nettype wire

// File: rtl/board_scan_controller_axis_tile_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_tile_tracker                                                  |
// | Tracks tile index and tile-local offset along one raster axis.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module axis_tile_tracker #(
  parameter int TILE = 106,
  parameter int GAP  = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        en_i,
  input  wire logic [11:0] origin_i,
  input  wire logic [11:0] cnt_i,
  output logic      [11:0] off_o,
  output logic      [1:0]  idx_o,
  output logic             in_range_o
);

  logic [11:0] off_q, off_d;
  logic [1:0]  idx_q, idx_d;
  logic        act_q, act_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      off_q <= '0;
      idx_q <= '0;
      act_q <= 1'b0;
    end else begin
      off_q <= off_d;
      idx_q <= idx_d;
      act_q <= act_d;
    end
  end

  always_comb begin
    off_d = off_q;
    idx_d = idx_q;
    act_d = act_q;
    if (en_i) begin
      if (cnt_i == origin_i) begin
        off_d = '0;
        idx_d = '0;
        act_d = 1'b1;
      end else if (act_q) begin
        if (off_q == 12'(TILE + GAP - 1)) begin
          off_d = '0;
          idx_d = idx_q + 2'd1;
        end else begin
          off_d = off_q + 12'd1;
        end
        // Last tile finished: stop before the index can wrap back to 0.
        if (idx_q == 2'd3 && off_q == 12'(TILE - 1)) begin
          act_d = 1'b0;
        end
      end
    end
  end

  assign off_o      = off_q;
  assign idx_o      = idx_q;
  assign in_range_o = act_q && (off_q < 12'(TILE));

endmodule
`default_nettype wire

// File: rtl/board_scan_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | board_scan_controller                                              |
// | Scans a double-buffered 4x4 board onto the raster for one renderer.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module board_scan_controller #(
  parameter int          BOARD_X0   = board_scan_controller_pkg::BOARD_X0,
  parameter int          BOARD_Y0   = board_scan_controller_pkg::BOARD_Y0,
  parameter int          TILE       = board_scan_controller_pkg::TILE,
  parameter int          GAP        = board_scan_controller_pkg::GAP,
  parameter int          V_ACTIVE   = board_scan_controller_pkg::V_ACTIVE,
  parameter int          RENDER_LAT = board_scan_controller_pkg::RENDER_LAT,
  parameter logic [11:0] BG_COLOR   = board_scan_controller_pkg::BG_COLOR
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic [11:0]        h_cnt,
  input  wire logic [11:0]        v_cnt,
  board_scan_controller_if.slave  wr,
  output logic      [3:0]         tile_state,
  output logic      [11:0]        tile_h_cnt,
  output logic      [11:0]        tile_v_cnt,
  input  wire logic [11:0]        tile_pix,
  output logic      [11:0]        vga_data
);
  import board_scan_controller_pkg::*;

  logic [BOARD_BITS-1:0] disp_q, pend_buf_q;
  logic                  pending_q;
  logic [11:0]           hx, vy;
  logic [1:0]            col, row;
  logic                  h_in, v_in;
  logic                  vblank_tick;
  logic                  in_tile_d, in_tile_q;
  logic [3:0]            tile_state_d, tile_state_q;
  logic [11:0]           tile_h_d, tile_h_q, tile_v_d, tile_v_q;
  logic [RENDER_LAT-1:0] dly_q;
  logic [11:0]           vga_d, vga_q;

  assign vblank_tick = (v_cnt == 12'(V_ACTIVE)) && (h_cnt == 12'd0);

  axis_tile_tracker #(.TILE(TILE), .GAP(GAP)) u_h_track (
    .clk(clk), .rst(rst), .en_i(1'b1), .origin_i(12'(BOARD_X0)), .cnt_i(h_cnt),
    .off_o(hx), .idx_o(col), .in_range_o(h_in)
  );

  axis_tile_tracker #(.TILE(TILE), .GAP(GAP)) u_v_track (
    .clk(clk), .rst(rst), .en_i(h_cnt == 12'd0), .origin_i(12'(BOARD_Y0)), .cnt_i(v_cnt),
    .off_o(vy), .idx_o(row), .in_range_o(v_in)
  );

  assign wr.board_wr_ready = !pending_q;
  assign wr.frame_swap     = vblank_tick && pending_q;

  // Displayed image only changes at the vblank tick, so a frame never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_q     <= '0;
      pend_buf_q <= '0;
      pending_q  <= 1'b0;
    end else if (vblank_tick && pending_q) begin
      disp_q    <= pend_buf_q;
      pending_q <= 1'b0;
    end else if (wr.board_wr_valid && !pending_q) begin
      pend_buf_q <= wr.board_wr_data;
      pending_q  <= 1'b1;
    end
  end

  always_comb begin
    in_tile_d    = h_in && v_in;
    tile_state_d = '0;
    tile_h_d     = '0;
    tile_v_d     = '0;
    if (in_tile_d) begin
      tile_state_d = disp_q[{tile_index(row, col), 2'b00} +: TILE_STATE_W];
      tile_h_d     = hx;
      tile_v_d     = vy;
    end
  end

  always_comb begin
    vga_d = dly_q[RENDER_LAT-1] ? tile_pix : BG_COLOR;
    if (v_cnt >= 12'(V_ACTIVE)) begin
      vga_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_tile_q    <= 1'b0;
      tile_state_q <= '0;
      tile_h_q     <= '0;
      tile_v_q     <= '0;
      dly_q        <= '0;
      vga_q        <= '0;
    end else begin
      in_tile_q    <= in_tile_d;
      tile_state_q <= tile_state_d;
      tile_h_q     <= tile_h_d;
      tile_v_q     <= tile_v_d;
      dly_q        <= RENDER_LAT'({dly_q, in_tile_q});
      vga_q        <= vga_d;
    end
  end

  assign tile_state = tile_state_q;
  assign tile_h_cnt = tile_h_q;
  assign tile_v_cnt = tile_v_q;
  assign vga_data   = vga_q;

endmodule
`default_nettype wire

// File: tb/tb_board_scan_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_board_scan_controller                                           |
// | Directed self-checking bench for board_scan_controller.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_board_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] h_cnt, v_cnt, tile_pix;
  logic [3:0]  tile_state;
  logic [11:0] tile_h_cnt, tile_v_cnt, vga_data;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] MAP_BOARD = 64'hFEDC_BA98_7654_3210;

  board_scan_controller_if bus ();

  board_scan_controller dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .wr(bus),
    .tile_state(tile_state), .tile_h_cnt(tile_h_cnt), .tile_v_cnt(tile_v_cnt),
    .tile_pix(tile_pix), .vga_data(vga_data)
  );

  always #5 clk = ~clk;

  task automatic step(input int h, input int v);
    h_cnt = 12'(h);
    v_cnt = 12'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic run_lines(input int v0, input int v1);
    for (int v = v0; v <= v1; v++) step(0, v);
  endtask

  task automatic sweep(input int h0, input int h1, input int v);
    for (int h = h0; h <= h1; h++) step(h, v);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.board_wr_valid = 1'b0;
    bus.board_wr_data  = '0;
    h_cnt = '0; v_cnt = '0; tile_pix = '0;
    #1 rst = 1'b0;
    #2;
    checks++; if (bus.board_wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.board_wr_ready); end
    checks++; if (bus.frame_swap !== 1'b0) begin failures++; $display("FAIL reset_swap got=%b exp=0", bus.frame_swap); end
    checks++; if (tile_state !== 4'h0) begin failures++; $display("FAIL reset_state got=%h exp=0", tile_state); end
    checks++; if (tile_h_cnt !== 12'h0) begin failures++; $display("FAIL reset_th got=%h exp=0", tile_h_cnt); end
    checks++; if (tile_v_cnt !== 12'h0) begin failures++; $display("FAIL reset_tv got=%h exp=0", tile_v_cnt); end
    checks++; if (vga_data !== 12'h0) begin failures++; $display("FAIL reset_vga got=%h exp=0", vga_data); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_handshake;
    bus.board_wr_valid = 1'b1;
    bus.board_wr_data  = 64'h1;
    step(500, 300);
    checks++; if (bus.board_wr_ready !== 1'b0) begin failures++; $display("FAIL hs_ready_drop got=%b exp=0", bus.board_wr_ready); end
    bus.board_wr_data = 64'h2;
    step(501, 300);
    checks++; if (bus.board_wr_ready !== 1'b0) begin failures++; $display("FAIL hs_held_off got=%b exp=0", bus.board_wr_ready); end
    checks++; if (bus.frame_swap !== 1'b0) begin failures++; $display("FAIL hs_no_early_swap got=%b exp=0", bus.frame_swap); end
    bus.board_wr_valid = 1'b0;
    h_cnt = 12'd0; v_cnt = 12'd480;
    #1;
    checks++; if (bus.frame_swap !== 1'b1) begin failures++; $display("FAIL hs_swap_pulse got=%b exp=1", bus.frame_swap); end
    @(posedge clk); #1;
    checks++; if (bus.frame_swap !== 1'b0) begin failures++; $display("FAIL hs_swap_once got=%b exp=0", bus.frame_swap); end
    checks++; if (bus.board_wr_ready !== 1'b1) begin failures++; $display("FAIL hs_ready_back got=%b exp=1", bus.board_wr_ready); end
    step(0, 8);
    sweep(1, 89, 8);
    checks++; if (tile_state !== 4'h1) begin failures++; $display("FAIL hs_tile0 got=%h exp=1", tile_state); end
    checks++; if (tile_h_cnt !== 12'd0) begin failures++; $display("FAIL hs_first_px_h got=%0d exp=0", tile_h_cnt); end
    checks++; if (tile_v_cnt !== 12'd0) begin failures++; $display("FAIL hs_first_px_v got=%0d exp=0", tile_v_cnt); end
  endtask

  task automatic test_mapping;
    bus.board_wr_valid = 1'b1;
    bus.board_wr_data  = MAP_BOARD;
    step(600, 8);
    bus.board_wr_valid = 1'b0;
    step(0, 480);
    run_lines(8, 129);
    sweep(1, 322, 129);
    checks++; if (tile_state !== 4'd6) begin failures++; $display("FAIL map_state got=%0d exp=6", tile_state); end
    checks++; if (tile_h_cnt !== 12'd5) begin failures++; $display("FAIL map_h got=%0d exp=5", tile_h_cnt); end
    checks++; if (tile_v_cnt !== 12'd7) begin failures++; $display("FAIL map_v got=%0d exp=7", tile_v_cnt); end
  endtask

  task automatic test_gap_latency;
    tile_pix = 12'h123;
    sweep(1, 194, 129);
    checks++; if (tile_h_cnt !== 12'd105) begin failures++; $display("FAIL edge_h got=%0d exp=105", tile_h_cnt); end
    checks++; if (tile_state !== 4'd4) begin failures++; $display("FAIL edge_state got=%0d exp=4", tile_state); end
    step(195, 129);
    checks++; if (tile_state !== 4'd0) begin failures++; $display("FAIL gap_state got=%0d exp=0", tile_state); end
    checks++; if (tile_h_cnt !== 12'd0) begin failures++; $display("FAIL gap_h got=%0d exp=0", tile_h_cnt); end
    step(196, 129);
    step(197, 129);
    checks++; if (vga_data !== 12'h123) begin failures++; $display("FAIL gap_vga_early got=%h exp=123", vga_data); end
    step(198, 129);
    checks++; if (vga_data !== 12'hBAA) begin failures++; $display("FAIL gap_vga_bg got=%h exp=baa", vga_data); end
    sweep(199, 203, 129);
    checks++; if (tile_state !== 4'd5) begin failures++; $display("FAIL lat_state got=%0d exp=5", tile_state); end
    checks++; if (tile_h_cnt !== 12'd0) begin failures++; $display("FAIL lat_h got=%0d exp=0", tile_h_cnt); end
    step(204, 129);
    step(205, 129);
    checks++; if (vga_data !== 12'hBAA) begin failures++; $display("FAIL lat_vga_early got=%h exp=baa", vga_data); end
    step(206, 129);
    checks++; if (vga_data !== 12'h123) begin failures++; $display("FAIL lat_vga_pix got=%h exp=123", vga_data); end
    step(300, 481);
    checks++; if (vga_data !== 12'h000) begin failures++; $display("FAIL vblank_vga got=%h exp=000", vga_data); end
  endtask

  task automatic test_no_tear;
    run_lines(130, 200);
    bus.board_wr_valid = 1'b1;
    bus.board_wr_data  = {16{4'hF}};
    step(700, 200);
    bus.board_wr_valid = 1'b0;
    checks++; if (bus.board_wr_ready !== 1'b0) begin failures++; $display("FAIL tear_ready got=%b exp=0", bus.board_wr_ready); end
    sweep(1, 322, 200);
    checks++; if (tile_state !== 4'd6) begin failures++; $display("FAIL tear_row1 got=%h exp=6", tile_state); end
    run_lines(201, 300);
    sweep(1, 322, 300);
    checks++; if (tile_state !== 4'hA) begin failures++; $display("FAIL tear_row2 got=%h exp=a", tile_state); end
    h_cnt = 12'd0; v_cnt = 12'd480;
    #1;
    checks++; if (bus.frame_swap !== 1'b1) begin failures++; $display("FAIL tear_swap got=%b exp=1", bus.frame_swap); end
    @(posedge clk); #1;
    step(0, 8);
    sweep(1, 89, 8);
    checks++; if (tile_state !== 4'hF) begin failures++; $display("FAIL tear_new got=%h exp=f", tile_state); end
  endtask

  task automatic test_async_reset;
    bus.board_wr_valid = 1'b1;
    bus.board_wr_data  = {16{4'h5}};
    step(800, 8);
    bus.board_wr_valid = 1'b0;
    checks++; if (bus.board_wr_ready !== 1'b0) begin failures++; $display("FAIL ar_pending got=%b exp=0", bus.board_wr_ready); end
    run_lines(9, 300);
    sweep(1, 322, 300);
    checks++; if (tile_state !== 4'hF) begin failures++; $display("FAIL ar_before got=%h exp=f", tile_state); end
    #2 rst = 1'b0;
    #1;
    checks++; if (tile_state !== 4'h0) begin failures++; $display("FAIL ar_state got=%h exp=0", tile_state); end
    checks++; if (tile_h_cnt !== 12'h0) begin failures++; $display("FAIL ar_h got=%h exp=0", tile_h_cnt); end
    checks++; if (tile_v_cnt !== 12'h0) begin failures++; $display("FAIL ar_v got=%h exp=0", tile_v_cnt); end
    checks++; if (vga_data !== 12'h0) begin failures++; $display("FAIL ar_vga got=%h exp=0", vga_data); end
    checks++; if (bus.board_wr_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b exp=1", bus.board_wr_ready); end
    #3 rst = 1'b1;
    sweep(1, 330, 301);
    checks++; if (tile_state !== 4'h0) begin failures++; $display("FAIL ar_untracked got=%h exp=0", tile_state); end
    checks++; if (vga_data !== 12'hBAA) begin failures++; $display("FAIL ar_bg got=%h exp=baa", vga_data); end
    h_cnt = 12'd0; v_cnt = 12'd480;
    #1;
    checks++; if (bus.frame_swap !== 1'b0) begin failures++; $display("FAIL ar_no_swap got=%b exp=0", bus.frame_swap); end
    @(posedge clk); #1;
    step(0, 8);
    sweep(1, 89, 8);
    checks++; if (tile_state !== 4'h0) begin failures++; $display("FAIL ar_disp_cleared got=%h exp=0", tile_state); end
    step(90, 8);
    step(91, 8);
    step(92, 8);
    checks++; if (vga_data !== 12'h123) begin failures++; $display("FAIL ar_resync_vga got=%h exp=123", vga_data); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_handshake();
    test_mapping();
    test_gap_latency();
    test_no_tear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
